mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and write-back. Unpacks the 166-bit execute-to-memory bus and runs one data-SRAM transaction per load/store over a req/addr_ok/data_ok handshake. Aligns and extends load data, reports address errors, and forwards HI/LO and destination information upstream for hazard resolution. Produces the 127-bit memory-to-write-back bus.

---
 rtl/mycpu_pkg.sv | 57 +++++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage_load_align.sv | 42 ++++
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mycpu_pkg.sv
// Shared definitions for the memory-access stage: bus widths, execute-bus field
// offsets, mem_control bit positions, SRAM size encodings and the FSM state type.
package mycpu_pkg;

  localparam int EXE_MEM_W = 166;
  localparam int MEM_WB_W  = 127;

  // EXE_MEM_bus_r field positions (LSB of multi-bit fields)
  localparam int EM_JBR     = 164;
  localparam int EM_CTRL_LO = 159;
  localparam int EM_SDATA   = 127;
  localparam int EM_RESULT  = 95;
  localparam int EM_LO      = 63;
  localparam int EM_HIW     = 62;
  localparam int EM_LOW     = 61;
  localparam int EM_MFHI    = 60;
  localparam int EM_MFLO    = 59;
  localparam int EM_MTC0    = 58;
  localparam int EM_MFC0    = 57;
  localparam int EM_CP0R    = 49;
  localparam int EM_SYSCALL = 48;
  localparam int EM_BREAK   = 47;
  localparam int EM_OV      = 46;
  localparam int EM_RI      = 45;
  localparam int EM_ERET    = 44;
  localparam int EM_WEN     = 43;
  localparam int EM_WDEST   = 38;
  localparam int EM_PC      = 6;
  localparam int EM_LSL     = 5;
  localparam int EM_LSR     = 4;

  // mem_control = {load, store, word, half, unsigned}
  localparam int MC_LOAD  = 4;
  localparam int MC_STORE = 3;
  localparam int MC_WORD  = 2;
  localparam int MC_HALF  = 1;
  localparam int MC_UNS   = 0;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-SRAM request/response channel between the memory stage (master) and the SRAM (slave).
interface mem_stage_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment: byte/half select with extension, word pass-through,
// and the LWL/LWR shifts whose byte merge is finished by write-back using rf_wbytes.
module load_align
  import mycpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  size_e       size,
  input  logic        uns,
  input  logic        ls_l,
  input  logic        ls_r,
  input  logic [3:0]  rf_wbytes,
  output logic [31:0] aligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [2:0]  keep_s;
  logic [4:0]  sh_s;

  assign byte_s = rdata[{addr, 3'b000} +: 8];
  assign half_s = addr[1] ? rdata[31:16] : rdata[15:0];
  // LWL shifts left by 8*(3-n) with n=cnt-1, LWR right by 8*n with n=4-cnt: both 8*(4-cnt)
  assign keep_s = 3'd4 - popcount4(rf_wbytes);
  assign sh_s   = {keep_s[1:0], 3'b000};

  always_comb begin
    aligned = rdata;
    if (ls_l) begin
      aligned = rdata << sh_s;
    end else if (ls_r) begin
      aligned = rdata >> sh_s;
    end else begin
      case (size)
        SZ_BYTE: aligned = uns ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
        SZ_HALF: aligned = uns ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
        default: aligned = rdata;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one SRAM transaction per load/store, load alignment,
// address-error detection and the memory-to-write-back bus.
module mem_stage
  import mycpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 MEM_valid,
  input  logic                 EXE_MEM_latch,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 cancel,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic                 MEM_hi_write,
  output logic                 MEM_lo_write,
  output logic [31:0]          MEM_hi_data,
  output logic [31:0]          MEM_lo_data,
  mem_stage_if.master          dbus
);

  logic [4:0]  ctrl_s;
  logic [31:0] store_data_s, exe_result_s, lo_result_s, aligned_s, mem_result_s;
  logic        load_s, store_s, mem_op_s, err_s, adel_s, ades_s, ls_l_s, ls_r_s;
  logic        req_s, rf_wen_s, unused_s;
  logic [3:0]  rf_wbytes_s, wstrb_s;
  logic [31:0] wdata_s;
  size_e       size_s;
  state_e      state_q, state_d;
  logic [31:0] load_q, load_d;

  assign ctrl_s       = EXE_MEM_bus_r[EM_CTRL_LO +: 5];
  assign store_data_s = EXE_MEM_bus_r[EM_SDATA +: 32];
  assign exe_result_s = EXE_MEM_bus_r[EM_RESULT +: 32];
  assign lo_result_s  = EXE_MEM_bus_r[EM_LO +: 32];
  assign ls_l_s       = EXE_MEM_bus_r[EM_LSL];
  assign ls_r_s       = EXE_MEM_bus_r[EM_LSR];
  assign rf_wbytes_s  = EXE_MEM_bus_r[3:0];
  assign unused_s     = &{1'b0, EXE_MEM_bus_r[EXE_MEM_W-1], EXE_MEM_bus_r[EM_JBR]};

  assign load_s   = ctrl_s[MC_LOAD];
  assign store_s  = ctrl_s[MC_STORE];
  assign mem_op_s = load_s | store_s;
  assign size_s   = ctrl_s[MC_WORD] ? SZ_WORD : (ctrl_s[MC_HALF] ? SZ_HALF : SZ_BYTE);
  // LWL/LWR are deliberately unaligned, so they never raise an address error
  assign err_s    = mem_op_s & ~(ls_l_s | ls_r_s) &
                    ((ctrl_s[MC_WORD] & (exe_result_s[1:0] != 2'b00)) |
                     (ctrl_s[MC_HALF] & exe_result_s[0]));
  assign adel_s   = err_s & load_s;
  assign ades_s   = err_s & store_s;
  assign rf_wen_s = EXE_MEM_bus_r[EM_WEN] & ~err_s;

  // store byte enables and replicated store data
  always_comb begin
    wstrb_s = 4'b0000;
    case (size_s)
      SZ_BYTE: wdata_s = {4{store_data_s[7:0]}};
      SZ_HALF: wdata_s = {2{store_data_s[15:0]}};
      default: wdata_s = store_data_s;
    endcase
    if (store_s && !err_s) begin
      case (size_s)
        SZ_BYTE: wstrb_s = 4'b0001 << exe_result_s[1:0];
        SZ_HALF: wstrb_s = exe_result_s[1] ? 4'b1100 : 4'b0011;
        default: wstrb_s = 4'b1111;
      endcase
    end else begin
      wstrb_s = 4'b0000;
    end
  end

  load_align u_align (
    .rdata     (dbus.data_rdata),
    .addr      (exe_result_s[1:0]),
    .size      (size_s),
    .uns       (ctrl_s[MC_UNS]),
    .ls_l      (ls_l_s),
    .ls_r      (ls_r_s),
    .rf_wbytes (rf_wbytes_s),
    .aligned   (aligned_s)
  );

  // request qualification and next-state / load-register logic
  always_comb begin
    req_s   = 1'b0;
    state_d = state_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        req_s = MEM_valid & mem_op_s & ~err_s & ~cancel;
        if (req_s) begin
          state_d = dbus.data_addr_ok ? ST_WAIT : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        req_s = MEM_valid;
        if (dbus.data_addr_ok) begin
          state_d = cancel ? ST_DRAIN : ST_WAIT;
        end else if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dbus.data_data_ok && cancel) begin
          state_d = ST_IDLE;
        end else if (dbus.data_data_ok) begin
          load_d  = aligned_s;
          state_d = ST_DONE;
        end else if (cancel) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (EXE_MEM_latch || !MEM_valid || cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        state_d = dbus.data_data_ok ? ST_IDLE : ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and captured load data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      load_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  assign mem_result_s = (load_s && !err_s) ? load_q : exe_result_s;
  assign MEM_over = MEM_valid & ((state_q == ST_DONE) |
                    ((state_q != ST_DRAIN) & (~mem_op_s | err_s)));

  assign dbus.data_req   = req_s;
  assign dbus.data_wr    = MEM_valid & store_s;
  assign dbus.data_size  = MEM_valid ? size_s : 2'b00;
  assign dbus.data_addr  = MEM_valid ? exe_result_s : 32'h0000_0000;
  assign dbus.data_wstrb = MEM_valid ? wstrb_s : 4'b0000;
  assign dbus.data_wdata = MEM_valid ? wdata_s : 32'h0000_0000;

  assign MEM_wdest    = EXE_MEM_bus_r[EM_WDEST +: 5] & {5{MEM_valid}};
  assign MEM_hi_write = EXE_MEM_bus_r[EM_HIW] & MEM_valid;
  assign MEM_lo_write = EXE_MEM_bus_r[EM_LOW] & MEM_valid;
  assign MEM_hi_data  = MEM_valid ? exe_result_s : 32'h0000_0000;
  assign MEM_lo_data  = MEM_valid ? lo_result_s : 32'h0000_0000;

  assign MEM_WB_bus = MEM_valid ? {rf_wen_s, EXE_MEM_bus_r[EM_WDEST +: 5], mem_result_s,
                                   lo_result_s, EXE_MEM_bus_r[EM_HIW], EXE_MEM_bus_r[EM_LOW],
                                   EXE_MEM_bus_r[EM_MFHI], EXE_MEM_bus_r[EM_MFLO],
                                   EXE_MEM_bus_r[EM_MTC0], EXE_MEM_bus_r[EM_MFC0],
                                   EXE_MEM_bus_r[EM_CP0R +: 8], EXE_MEM_bus_r[EM_SYSCALL],
                                   EXE_MEM_bus_r[EM_BREAK], EXE_MEM_bus_r[EM_OV],
                                   EXE_MEM_bus_r[EM_RI], EXE_MEM_bus_r[EM_ERET],
                                   adel_s, ades_s, EXE_MEM_bus_r[EM_PC +: 32], rf_wbytes_s}
                                : {MEM_WB_W{1'b0}};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus hand-written
// multi-cycle SRAM handshake sequences.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn, MEM_valid, EXE_MEM_latch, cancel;
  logic [165:0] EXE_MEM_bus_r;
  logic         MEM_over, MEM_hi_write, MEM_lo_write;
  logic [126:0] MEM_WB_bus;
  logic [4:0]   MEM_wdest;
  logic [31:0]  MEM_hi_data, MEM_lo_data;
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] LO_C = 32'h0BAD_F00D;
  localparam logic [31:0] PC_C = 32'hBFC0_0100;

  mem_stage_if dif();

  mem_stage dut (
    .clk(clk), .resetn(resetn), .MEM_valid(MEM_valid), .EXE_MEM_latch(EXE_MEM_latch),
    .EXE_MEM_bus_r(EXE_MEM_bus_r), .cancel(cancel), .MEM_over(MEM_over),
    .MEM_WB_bus(MEM_WB_bus), .MEM_wdest(MEM_wdest), .MEM_hi_write(MEM_hi_write),
    .MEM_lo_write(MEM_lo_write), .MEM_hi_data(MEM_hi_data), .MEM_lo_data(MEM_lo_data),
    .dbus(dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, cancel;
    logic [4:0]  ctrl;
    logic        ls_l, ls_r;
    logic [3:0]  wb;
    logic [31:0] addr, rt;
    logic        e_over, e_req, e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic        e_adel, e_ades, e_wen;
    logic [31:0] e_res;
  } vec_t;

  vec_t vt[10];

  function automatic logic [165:0] mk_bus(input logic [4:0] ctrl, input logic ls_l,
      input logic ls_r, input logic [3:0] wb, input logic [31:0] addr, input logic [31:0] rt);
    logic [165:0] b;
    b = '0;
    b[163:159] = ctrl;
    b[158:127] = rt;
    b[126:95]  = addr;
    b[94:63]   = LO_C;
    b[62]      = 1'b1;
    b[43]      = 1'b1;
    b[42:38]   = 5'd9;
    b[37:6]    = PC_C;
    b[5]       = ls_l;
    b[4]       = ls_r;
    b[3:0]     = wb;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic aok, input logic dok,
                       input logic [31:0] rd);
    MEM_valid = v; cancel = c;
    dif.data_addr_ok = aok; dif.data_data_ok = dok; dif.data_rdata = rd;
  endtask

  // one load with minimum latency; result checked in DONE, then stage released
  task automatic do_load(input string nm, input logic [165:0] bus, input logic [31:0] rd,
                         input logic [31:0] exp);
    EXE_MEM_bus_r = bus;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk); chk({nm, "_t0_req"}, {31'd0, dif.data_req}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, rd);
    @(negedge clk); chk({nm, "_t1_over"}, {31'd0, MEM_over}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk({nm, "_t2_over"}, {31'd0, MEM_over}, 32'd1);
    chk({nm, "_t2_res"}, MEM_WB_bus[120:89], exp);
    tick();
    MEM_valid = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0; EXE_MEM_latch = 1'b0;
    EXE_MEM_bus_r = mk_bus(5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_over", {31'd0, MEM_over}, 32'd0);
    chk("rst_req", {31'd0, dif.data_req}, 32'd0);
    chk("rst_bus_lo", MEM_WB_bus[31:0], 32'd0);
    chk("rst_bus_res", MEM_WB_bus[120:89], 32'd0);
    chk("rst_addr", dif.data_addr, 32'd0);
    resetn = 1'b1;
    tick();

    //        vld  cnc  ctrl      L     R     wb       addr          rt
    //        over req  wr   size   wstrb    wdata         adel ades wen  res
    vt[0] = '{1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0,
              1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1234_5678};
    vt[1] = '{1'b1, 1'b0, 5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0101, 32'h0,
              1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0101};
    vt[2] = '{1'b1, 1'b0, 5'b01100, 1'b0, 1'b0, 4'b1111, 32'h0000_0102, 32'h0,
              1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0000_0102};
    vt[3] = '{1'b1, 1'b0, 5'b10010, 1'b0, 1'b0, 4'b1111, 32'h0000_0103, 32'h0,
              1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0103};
    vt[4] = '{1'b1, 1'b1, 5'b01000, 1'b0, 1'b0, 4'b1111, 32'h0000_0301, 32'h0000_00A5,
              1'b0, 1'b0, 1'b1, 2'd0, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 32'h0000_0301};
    vt[5] = '{1'b1, 1'b1, 5'b01010, 1'b0, 1'b0, 4'b1111, 32'h0000_0300, 32'h1234_BEEF,
              1'b0, 1'b0, 1'b1, 2'd1, 4'b0011, 32'hBEEF_BEEF, 1'b0, 1'b0, 1'b1, 32'h0000_0300};
    vt[6] = '{1'b1, 1'b1, 5'b01100, 1'b0, 1'b0, 4'b1111, 32'h0000_0304, 32'hCAFE_F00D,
              1'b0, 1'b0, 1'b1, 2'd2, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 32'h0000_0304};
    vt[7] = '{1'b1, 1'b1, 5'b10011, 1'b0, 1'b0, 4'b1111, 32'h0000_0102, 32'h0,
              1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[8] = '{1'b1, 1'b1, 5'b10100, 1'b1, 1'b0, 4'b1100, 32'h0000_0101, 32'h0,
              1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[9] = '{1'b0, 1'b0, 5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0101, 32'h0,
              1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 10; i++) begin
      EXE_MEM_bus_r = mk_bus(vt[i].ctrl, vt[i].ls_l, vt[i].ls_r, vt[i].wb, vt[i].addr, vt[i].rt);
      drive(vt[i].valid, vt[i].cancel, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_over", i), {31'd0, MEM_over}, {31'd0, vt[i].e_over});
      chk($sformatf("v%0d_req", i), {31'd0, dif.data_req}, {31'd0, vt[i].e_req});
      chk($sformatf("v%0d_wr", i), {31'd0, dif.data_wr}, {31'd0, vt[i].e_wr});
      chk($sformatf("v%0d_size", i), {30'd0, dif.data_size}, {30'd0, vt[i].e_size});
      chk($sformatf("v%0d_wstrb", i), {28'd0, dif.data_wstrb}, {28'd0, vt[i].e_wstrb});
      chk($sformatf("v%0d_wdata", i), dif.data_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_adel", i), {31'd0, MEM_WB_bus[37]}, {31'd0, vt[i].e_adel});
      chk($sformatf("v%0d_ades", i), {31'd0, MEM_WB_bus[36]}, {31'd0, vt[i].e_ades});
      chk($sformatf("v%0d_wen", i), {31'd0, MEM_WB_bus[126]}, {31'd0, vt[i].e_wen});
      chk($sformatf("v%0d_res", i), MEM_WB_bus[120:89], vt[i].e_res);
      chk($sformatf("v%0d_wdest", i), {27'd0, MEM_wdest}, vt[i].valid ? 32'd9 : 32'd0);
      chk($sformatf("v%0d_hiw", i), {31'd0, MEM_hi_write}, {31'd0, vt[i].valid});
      chk($sformatf("v%0d_lodata", i), MEM_lo_data, vt[i].valid ? LO_C : 32'h0);
      chk($sformatf("v%0d_addr", i), dif.data_addr, vt[i].valid ? vt[i].addr : 32'h0);
      chk($sformatf("v%0d_pc", i), MEM_WB_bus[35:4], vt[i].valid ? PC_C : 32'h0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // LB at 0x103, minimum latency, MEM_over only at t2
    EXE_MEM_bus_r = mk_bus(5'b10000, 1'b0, 1'b0, 4'b1111, 32'h0000_0103, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("lb_t0_req", {31'd0, dif.data_req}, 32'd1);
    chk("lb_t0_size", {30'd0, dif.data_size}, 32'd0);
    chk("lb_t0_over", {31'd0, MEM_over}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80FF_1234);
    @(negedge clk);
    chk("lb_t1_req", {31'd0, dif.data_req}, 32'd0);
    chk("lb_t1_over", {31'd0, MEM_over}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("lb_t2_over", {31'd0, MEM_over}, 32'd1);
    chk("lb_t2_res", MEM_WB_bus[120:89], 32'hFFFF_FF80);
    chk("lb_t2_req", {31'd0, dif.data_req}, 32'd0);
    tick();
    MEM_valid = 1'b0;
    @(negedge clk); chk("lb_t3_over", {31'd0, MEM_over}, 32'd0);
    tick();

    // SH at 0x202 with addr_ok held off for three cycles
    EXE_MEM_bus_r = mk_bus(5'b01010, 1'b0, 1'b0, 4'b1111, 32'h0000_0202, 32'h0000_ABCD);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, (c == 3), 1'b0, 32'h0);
      @(negedge clk);
      chk($sformatf("sh_c%0d_req", c), {31'd0, dif.data_req}, 32'd1);
      chk($sformatf("sh_c%0d_wstrb", c), {28'd0, dif.data_wstrb}, 32'hC);
      chk($sformatf("sh_c%0d_wdata", c), dif.data_wdata, 32'hABCD_ABCD);
      chk($sformatf("sh_c%0d_over", c), {31'd0, MEM_over}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    chk("sh_c4_req", {31'd0, dif.data_req}, 32'd0);
    chk("sh_c4_over", {31'd0, MEM_over}, 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("sh_c5_over", {31'd0, MEM_over}, 32'd1);
    tick();
    MEM_valid = 1'b0;
    tick();

    do_load("lwl", mk_bus(5'b10100, 1'b1, 1'b0, 4'b1100, 32'h0000_1001, 32'h0),
            32'h1122_3344, 32'h3344_0000);
    do_load("lwr", mk_bus(5'b10100, 1'b0, 1'b1, 4'b0011, 32'h0000_1002, 32'h0),
            32'h1122_3344, 32'h0000_1122);
    do_load("lhu", mk_bus(5'b10011, 1'b0, 1'b0, 4'b1111, 32'h0000_0102, 32'h0),
            32'h8001_7F02, 32'h0000_8001);

    // cancel while waiting for data_ok: drain, no request, no MEM_over
    EXE_MEM_bus_r = mk_bus(5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("cw_t1_over", {31'd0, MEM_over}, 32'd0);
    tick();
    for (int c = 2; c < 4; c++) begin
      drive(1'b1, 1'b0, 1'b0, (c == 3), 32'h5555_AAAA);
      @(negedge clk);
      chk($sformatf("cw_t%0d_req", c), {31'd0, dif.data_req}, 32'd0);
      chk($sformatf("cw_t%0d_over", c), {31'd0, MEM_over}, 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("cw_t4_idle_req", {31'd0, dif.data_req}, 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();

    // back-to-back LWs with EXE_MEM_latch in DONE
    EXE_MEM_bus_r = mk_bus(5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0200, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    EXE_MEM_bus_r = mk_bus(5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0204, 32'h0);
    EXE_MEM_latch = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_done1_over", {31'd0, MEM_over}, 32'd1);
    chk("b2b_done1_res", MEM_WB_bus[120:89], 32'hDEAD_BEEF);
    chk("b2b_done1_req", {31'd0, dif.data_req}, 32'd0);
    tick();
    EXE_MEM_latch = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_req2", {31'd0, dif.data_req}, 32'd1);
    chk("b2b_addr2", dif.data_addr, 32'h0000_0204);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0123_4567);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("b2b_done2_over", {31'd0, MEM_over}, 32'd1);
    chk("b2b_done2_res", MEM_WB_bus[120:89], 32'h0123_4567);
    tick();

    // reset mid-transaction returns to IDLE
    EXE_MEM_bus_r = mk_bus(5'b10100, 1'b0, 1'b0, 4'b1111, 32'h0000_0300, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, dif.data_req}, 32'd1);
    chk("rst_mid_over", {31'd0, MEM_over}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
